axi_wr_resp_monitor: RTL
========================

AXI_WR_RESP_MONITOR -- requirements
Module: axi_wr_resp_monitor

Interface
REQ-001 Parameter P_MAX_OUTSTANDING, default 8: max AW bursts awaiting B response.
REQ-002 Parameter P_TIMEOUT, default 1024: cycles without a B handshake, while outstanding>0, before timeout.
REQ-003 Parameter P_AXI_ID, default 4'd0: expected BID.
REQ-004 i_axi_clk  input  1  sole clock; all logic rising-edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_axi_aw_valid  input  1  AW valid observed from the write master.
REQ-007 i_axi_aw_ready  input  1  AW ready observed from the slave.
REQ-008 i_axi_bid  input  4  write response ID.
REQ-009 i_axi_bresp  input  2  write response code; 2'b00 = OKAY.
REQ-010 i_axi_bvalid  input  1  write response valid.
REQ-011 o_axi_bready  output  1  write response ready, registered.
REQ-012 i_err_clr  input  1  single-cycle clear of sticky errors and error count.
REQ-013 o_aw_allow  output  1  master may issue a new AW burst.
REQ-014 o_outstanding  output  clog2(P_MAX_OUTSTANDING)+1  current outstanding-burst count.
REQ-015 o_wr_done  output  1  one-cycle pulse when all outstanding bursts have been acknowledged.
REQ-016 o_err_resp / o_err_id / o_err_timeout / o_err_unexp  output  1 each  sticky error flags.
REQ-017 o_err_cnt  output  16  saturating count of bad responses.

Function
REQ-018 AW event = i_axi_aw_valid & i_axi_aw_ready; B event = i_axi_bvalid & o_axi_bready.
REQ-019 Counter update per cycle: +1 on AW only, -1 on B only, unchanged on both or neither.
REQ-020 AW event at count==P_MAX_OUTSTANDING: count holds, o_err_unexp set.
REQ-021 B event at count==0 without a same-cycle AW event: count holds at 0, o_err_unexp set.
REQ-022 o_aw_allow = (count < P_MAX_OUTSTANDING) & (state != S_ERR); combinational from registered state.
REQ-023 o_axi_bready is 0 during reset and 1 from the first clock after reset deassertion; it stays 1 in all states, including S_ERR, so the monitor drains responses.
REQ-024 On a B event with i_axi_bresp != 2'b00: o_err_resp set the next cycle.
REQ-025 On a B event with i_axi_bid != P_AXI_ID: o_err_id set the next cycle.
REQ-026 o_err_cnt increments by exactly 1 per B event with a bad response or a bad ID (both together count once); it saturates at 16'hFFFF.
REQ-027 Timeout counter:
- cleared on any B event, and whenever count==0
- otherwise increments each cycle
- on reaching P_TIMEOUT-1, o_err_timeout is set and the timeout counter holds.
REQ-028 o_wr_done pulses high for 1 cycle, the cycle after count transitions 1->0.
REQ-029 FSM states:
- S_IDLE (count==0)
- S_WAIT (count>0)
- S_ERR (any sticky flag set)
REQ-030 FSM transitions:
- S_IDLE->S_WAIT on count becoming >0
- S_WAIT->S_IDLE on count becoming 0
- any state->S_ERR on any error being set
- S_ERR->S_IDLE on i_err_clr with count==0
- S_ERR->S_WAIT on i_err_clr with count>0
REQ-031 i_err_clr clears all sticky flags and o_err_cnt in 1 cycle; if a new error occurs in the same cycle, the error wins (flag set, o_err_cnt=1).
REQ-032 Counting continues in S_ERR; outstanding tracking is never lost.
REQ-033 Output latency: all flags, counters and o_wr_done are registered, 1 cycle after the causing event.

Reset
REQ-034 Asserting i_rst at any time, including mid-burst, immediately forces the following, with no pending-response recovery:
- state S_IDLE
- count 0, timeout counter 0
- all flags 0, o_err_cnt 0
- o_axi_bready 0, o_wr_done 0
- o_aw_allow 1
REQ-035 Normal operation resumes on the first rising edge after i_rst deasserts.

Verification
REQ-036 3 AW events back-to-back, then 3 OKAY B events with BID=0 -> o_outstanding steps 1,2,3,2,1,0; o_wr_done pulses once; no flags set.
REQ-037 8 AW events with no B -> o_aw_allow=0 at count 8; a ninth forced AW event -> count stays 8 and o_err_unexp=1.
REQ-038 1 AW event, B with bresp=2'b10 and bid=4'd3 -> o_err_resp=1, o_err_id=1, o_err_cnt=1, state S_ERR, o_aw_allow=0; i_err_clr pulse -> flags 0, o_err_cnt 0, state S_IDLE.
REQ-039 1 AW event, then no B for 1023 cycles -> o_err_timeout=1 exactly at cycle 1023 after the AW event; a late OKAY B event -> count 0 and the flag stays set.
REQ-040 Same-cycle AW and B events at count 2 -> count stays 2 and o_wr_done is not pulsed; i_rst asserted with count 2 -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/axi_wr_resp_monitor.sv
// AXI write-response monitor: tracks outstanding AW bursts against B
// responses, throttles new bursts, and records sticky protocol errors.
module axi_wr_resp_monitor #(
  parameter int         P_MAX_OUTSTANDING = 8,
  parameter int         P_TIMEOUT         = 1024,
  parameter logic [3:0] P_AXI_ID          = 4'd0
) (
  input  logic                                 i_axi_clk,
  input  logic                                 i_rst,
  input  logic                                 i_axi_aw_valid,
  input  logic                                 i_axi_aw_ready,
  input  logic [3:0]                           i_axi_bid,
  input  logic [1:0]                           i_axi_bresp,
  input  logic                                 i_axi_bvalid,
  output logic                                 o_axi_bready,
  input  logic                                 i_err_clr,
  output logic                                 o_aw_allow,
  output logic [$clog2(P_MAX_OUTSTANDING):0]   o_outstanding,
  output logic                                 o_wr_done,
  output logic                                 o_err_resp,
  output logic                                 o_err_id,
  output logic                                 o_err_timeout,
  output logic                                 o_err_unexp,
  output logic [15:0]                          o_err_cnt
);

  localparam int                LP_CW   = $clog2(P_MAX_OUTSTANDING) + 1;
  localparam logic [LP_CW-1:0]  LP_MAX  = LP_CW'(P_MAX_OUTSTANDING);
  localparam int                LP_TW   = $clog2(P_TIMEOUT) + 1;
  localparam logic [LP_TW-1:0]  LP_TLIM = LP_TW'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} t_state;

  t_state             r_state, w_state_nxt;
  logic [LP_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [LP_TW-1:0]   r_tmo, w_tmo_nxt;
  logic               r_bready, r_wr_done;
  logic               r_err_resp, r_err_id, r_err_timeout, r_err_unexp;
  logic [15:0]        r_err_cnt;

  logic w_aw, w_b, w_ovf, w_unf, w_bad_resp, w_bad_id, w_bad, w_tmo_hit, w_new_err;

  assign w_aw       = i_axi_aw_valid & i_axi_aw_ready;
  assign w_b        = i_axi_bvalid & r_bready;
  // An AW/B pair in one cycle is a net-zero update, never an over/underflow.
  assign w_ovf      = w_aw & ~w_b & (r_cnt == LP_MAX);
  assign w_unf      = w_b & ~w_aw & (r_cnt == '0);
  assign w_bad_resp = w_b & (i_axi_bresp != 2'b00);
  assign w_bad_id   = w_b & (i_axi_bid != P_AXI_ID);
  assign w_bad      = w_bad_resp | w_bad_id;
  assign w_tmo_hit  = (w_tmo_nxt == LP_TLIM) & (r_tmo != LP_TLIM);
  assign w_new_err  = w_bad | w_ovf | w_unf | w_tmo_hit;

  // Next outstanding count; overflow/underflow hold the count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_aw & ~w_b & ~w_ovf)      w_cnt_nxt = r_cnt + LP_CW'(1);
    else if (w_b & ~w_aw & ~w_unf) w_cnt_nxt = r_cnt - LP_CW'(1);
  end

  // Next timeout value: idle or acknowledged resets it, otherwise count to the limit and hold.
  always_comb begin
    w_tmo_nxt = r_tmo;
    if (w_b || (r_cnt == '0))  w_tmo_nxt = '0;
    else if (r_tmo != LP_TLIM) w_tmo_nxt = r_tmo + LP_TW'(1);
  end

  // Next FSM state; a fresh error always wins over a clear.
  always_comb begin
    w_state_nxt = r_state;
    if (w_new_err) begin
      w_state_nxt = S_ERR;
    end else if (r_state != S_ERR || i_err_clr) begin
      w_state_nxt = (w_cnt_nxt == '0) ? S_IDLE : S_WAIT;
    end
  end

  // State, counters and handshake registers.
  always_ff @(posedge i_axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_bready  <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_bready  <= 1'b1;
      r_wr_done <= (r_cnt == LP_CW'(1)) & (w_cnt_nxt == '0);
    end
  end

  // Sticky error flags and saturating bad-response count.
  always_ff @(posedge i_axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_resp    <= 1'b0;
      r_err_id      <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_unexp   <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_err_resp    <= w_bad_resp | (r_err_resp & ~i_err_clr);
      r_err_id      <= w_bad_id | (r_err_id & ~i_err_clr);
      r_err_timeout <= w_tmo_hit | (r_err_timeout & ~i_err_clr);
      r_err_unexp   <= w_ovf | w_unf | (r_err_unexp & ~i_err_clr);
      if (i_err_clr)                            r_err_cnt <= {15'd0, w_bad};
      else if (w_bad && r_err_cnt != 16'hFFFF)  r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_axi_bready  = r_bready;
  assign o_aw_allow    = (r_cnt < LP_MAX) & (r_state != S_ERR);
  assign o_outstanding = r_cnt;
  assign o_wr_done     = r_wr_done;
  assign o_err_resp    = r_err_resp;
  assign o_err_id      = r_err_id;
  assign o_err_timeout = r_err_timeout;
  assign o_err_unexp   = r_err_unexp;
  assign o_err_cnt     = r_err_cnt;

endmodule
